// File: rtl/vga_pattern_engine.sv
// VGA timing generator with a selectable test pattern (solid, colour bars, checkerboard, gradient).
// Optional build macro VGA_BORDER_EN forces a one-pixel all-ones frame border around the visible area.
module vga_pattern_engine #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   COLOR_W  = 4,
    parameter int   CHK_LOG2 = 5,
    parameter int   XY_W     = 11
) (
    input  logic                   iVGA_CLK,
    input  logic                   iRST_n,
    input  logic [1:0]             iMode,
    input  logic [3*COLOR_W-1:0]   iSolid,
    output logic                   oHS,
    output logic                   oVS,
    output logic                   oDE,
    output logic [COLOR_W-1:0]     oRed,
    output logic [COLOR_W-1:0]     oGreen,
    output logic [COLOR_W-1:0]     oBlue,
    output logic [XY_W-1:0]        oX,
    output logic [XY_W-1:0]        oY,
    output logic [15:0]            oFrame
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int RGB_W   = 3 * COLOR_W;

    localparam logic [XY_W-1:0] H_LAST   = XY_W'(H_TOTAL - 1);
    localparam logic [XY_W-1:0] V_LAST   = XY_W'(V_TOTAL - 1);
    localparam logic [XY_W-1:0] H_ACT    = XY_W'(H_ACTIVE);
    localparam logic [XY_W-1:0] V_ACT    = XY_W'(V_ACTIVE);
    localparam logic [XY_W-1:0] HS_START = XY_W'(H_ACTIVE + H_FP);
    localparam logic [XY_W-1:0] HS_END   = XY_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XY_W-1:0] VS_START = XY_W'(V_ACTIVE + V_FP);
    localparam logic [XY_W-1:0] VS_END   = XY_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [XY_W-1:0] BAR_LAST = XY_W'(BAR_W - 1);

    // Counters and per-frame latched configuration
    logic [XY_W-1:0]  r_h_cnt;
    logic [XY_W-1:0]  r_v_cnt;
    logic [XY_W-1:0]  r_bar_pos;
    logic [2:0]       r_bar_idx;
    logic [1:0]       r_mode;
    logic [RGB_W-1:0] r_solid;
    logic [15:0]      r_frame;

    logic w_h_last;
    logic w_v_last;
    logic w_frame_end;

    assign w_h_last    = (r_h_cnt == H_LAST);
    assign w_v_last    = (r_v_cnt == V_LAST);
    assign w_frame_end = w_h_last && w_v_last;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
            r_bar_pos <= '0;
            r_bar_idx <= '0;
            r_mode    <= '0;
            r_solid   <= '0;
            r_frame   <= '0;
        end else begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end

            // Bar tracker follows h_cnt; it saturates at bar 7 for any remainder pixels
            if (w_h_last) begin
                r_bar_pos <= '0;
                r_bar_idx <= '0;
            end else if (r_bar_pos == BAR_LAST) begin
                r_bar_pos <= '0;
                if (r_bar_idx != 3'd7) begin
                    r_bar_idx <= r_bar_idx + 3'd1;
                end
            end else begin
                r_bar_pos <= r_bar_pos + 1'b1;
            end

            if (w_frame_end) begin
                r_mode  <= iMode;
                r_solid <= iSolid;
                r_frame <= r_frame + 16'd1;
            end
        end
    end

    // Stage 1: decode the current counts
    logic               w_de;
    logic               w_hs_act;
    logic               w_vs_act;
    logic               w_chk;
    logic [COLOR_W-1:0] w_grad;

    assign w_de     = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_hs_act = (r_h_cnt >= HS_START) && (r_h_cnt < HS_END);
    assign w_vs_act = (r_v_cnt >= VS_START) && (r_v_cnt < VS_END);
    assign w_chk    = r_h_cnt[CHK_LOG2] ^ r_v_cnt[CHK_LOG2];

    generate
        if (XY_W >= COLOR_W + 4) begin : g_grad_full
            assign w_grad = r_h_cnt[COLOR_W+3:4];
        end else if (XY_W > 4) begin : g_grad_pad
            assign w_grad = {{(COLOR_W + 4 - XY_W){1'b0}}, r_h_cnt[XY_W-1:4]};
        end else begin : g_grad_zero
            assign w_grad = '0;
        end
    endgenerate

    logic               r_s1_de;
    logic               r_s1_hs;
    logic               r_s1_vs;
    logic               r_s1_chk;
    logic [2:0]         r_s1_bar;
    logic [COLOR_W-1:0] r_s1_grad;
    logic [1:0]         r_s1_mode;
    logic [RGB_W-1:0]   r_s1_solid;
    logic [XY_W-1:0]    r_s1_x;
    logic [XY_W-1:0]    r_s1_y;

`ifdef VGA_BORDER_EN
    logic w_border;
    logic r_s1_border;

    assign w_border = (r_h_cnt == '0) || (r_h_cnt == XY_W'(H_ACTIVE - 1)) ||
                      (r_v_cnt == '0) || (r_v_cnt == XY_W'(V_ACTIVE - 1));

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_s1_border <= 1'b0;
        end else begin
            r_s1_border <= w_border;
        end
    end
`endif

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_s1_de    <= 1'b0;
            r_s1_hs    <= ~HS_POL;
            r_s1_vs    <= ~VS_POL;
            r_s1_chk   <= 1'b0;
            r_s1_bar   <= '0;
            r_s1_grad  <= '0;
            r_s1_mode  <= '0;
            r_s1_solid <= '0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
        end else begin
            r_s1_de    <= w_de;
            r_s1_hs    <= w_hs_act ? HS_POL : ~HS_POL;
            r_s1_vs    <= w_vs_act ? VS_POL : ~VS_POL;
            r_s1_chk   <= w_chk;
            r_s1_bar   <= r_bar_idx;
            r_s1_grad  <= w_grad;
            r_s1_mode  <= r_mode;
            r_s1_solid <= r_solid;
            r_s1_x     <= r_h_cnt;
            r_s1_y     <= r_v_cnt;
        end
    end

    // Stage 2: pick the pattern colour and register every output together
    logic [2:0]       w_bar_rgb;
    logic [RGB_W-1:0] w_pix;

    always_comb begin
        w_bar_rgb = 3'b000;
        case (r_s1_bar)
            3'd0:    w_bar_rgb = 3'b111;
            3'd1:    w_bar_rgb = 3'b110;
            3'd2:    w_bar_rgb = 3'b011;
            3'd3:    w_bar_rgb = 3'b010;
            3'd4:    w_bar_rgb = 3'b101;
            3'd5:    w_bar_rgb = 3'b100;
            3'd6:    w_bar_rgb = 3'b001;
            default: w_bar_rgb = 3'b000;
        endcase
    end

    always_comb begin
        w_pix = '0;
        case (r_s1_mode)
            2'd0:    w_pix = r_s1_solid;
            2'd1:    w_pix = {{COLOR_W{w_bar_rgb[2]}}, {COLOR_W{w_bar_rgb[1]}}, {COLOR_W{w_bar_rgb[0]}}};
            2'd2:    w_pix = {RGB_W{r_s1_chk}};
            default: w_pix = {r_s1_grad, r_s1_grad, r_s1_grad};
        endcase
`ifdef VGA_BORDER_EN
        if (r_s1_border) begin
            w_pix = '1;
        end
`endif
        if (!r_s1_de) begin
            w_pix = '0;
        end
    end

    logic             r_hs;
    logic             r_vs;
    logic             r_de;
    logic [RGB_W-1:0] r_rgb;
    logic [XY_W-1:0]  r_x;
    logic [XY_W-1:0]  r_y;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_hs  <= ~HS_POL;
            r_vs  <= ~VS_POL;
            r_de  <= 1'b0;
            r_rgb <= '0;
            r_x   <= '0;
            r_y   <= '0;
        end else begin
            r_hs  <= r_s1_hs;
            r_vs  <= r_s1_vs;
            r_de  <= r_s1_de;
            r_rgb <= w_pix;
            r_x   <= r_s1_x;
            r_y   <= r_s1_y;
        end
    end

    assign oHS    = r_hs;
    assign oVS    = r_vs;
    assign oDE    = r_de;
    assign oRed   = r_rgb[RGB_W-1:2*COLOR_W];
    assign oGreen = r_rgb[2*COLOR_W-1:COLOR_W];
    assign oBlue  = r_rgb[COLOR_W-1:0];
    assign oX     = r_x;
    assign oY     = r_y;
    assign oFrame = r_frame;

endmodule

// File: tb/tb_vga_pattern_engine.sv
// Bench for vga_pattern_engine with shortened timing; every output cycle is compared
// against a pixel model computed from coordinates, the frame's latched mode and the 2-cycle latency.
module tb_vga_pattern_engine;

    localparam int   HA  = 64;
    localparam int   HFP = 4;
    localparam int   HSY = 8;
    localparam int   HBP = 4;
    localparam int   VA  = 16;
    localparam int   VFP = 2;
    localparam int   VSY = 2;
    localparam int   VBP = 3;
    localparam int   HT  = HA + HFP + HSY + HBP;
    localparam int   VT  = VA + VFP + VSY + VBP;
    localparam int   CHK = 3;
    localparam logic HSP = 1'b0;
    localparam logic VSP = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [11:0] solid = 12'h000;
    logic        oHS, oVS, oDE;
    logic [3:0]  oRed, oGreen, oBlue;
    logic [10:0] oX, oY;
    logic [15:0] oFrame;

    always #5 clk = ~clk;

    vga_pattern_engine #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(HSP), .VS_POL(VSP),
        .COLOR_W(4), .CHK_LOG2(CHK), .XY_W(11)
    ) dut (
        .iVGA_CLK(clk), .iRST_n(rst_n), .iMode(mode), .iSolid(solid),
        .oHS(oHS), .oVS(oVS), .oDE(oDE),
        .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
        .oX(oX), .oY(oY), .oFrame(oFrame)
    );

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] rgb;
        logic [10:0] x;
        logic [10:0] y;
    } pix_t;

    pix_t        hist[$];
    int          total = 0;
    int          bad = 0;
    int          m_h, m_v, k;
    logic [1:0]  m_mode;
    logic [11:0] m_solid;
    logic [15:0] m_frame;
    int          de_cnt, hs_cnt;

    function automatic logic [2:0] bar_colour(int idx);
        case (idx)
            0:       return 3'b111;
            1:       return 3'b110;
            2:       return 3'b011;
            3:       return 3'b010;
            4:       return 3'b101;
            5:       return 3'b100;
            6:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic pix_t reset_pix();
        pix_t p;
        p    = '0;
        p.hs = ~HSP;
        p.vs = ~VSP;
        return p;
    endfunction

    function automatic pix_t model(int x, int y, logic [1:0] md, logic [11:0] sol);
        pix_t       p;
        int         bar;
        logic [2:0] bc;
        logic [3:0] c;
        p     = '0;
        p.x   = 11'(x);
        p.y   = 11'(y);
        p.hs  = (x >= HA + HFP && x < HA + HFP + HSY) ? HSP : ~HSP;
        p.vs  = (y >= VA + VFP && y < VA + VFP + VSY) ? VSP : ~VSP;
        p.de  = (x < HA) && (y < VA);
        if (p.de) begin
            case (md)
                2'd0: p.rgb = sol;
                2'd1: begin
                    bar = x / (HA / 8);
                    if (bar > 7) bar = 7;
                    bc = bar_colour(bar);
                    p.rgb = {{4{bc[2]}}, {4{bc[1]}}, {4{bc[0]}}};
                end
                2'd2: p.rgb = ((((x >> CHK) ^ (y >> CHK)) & 1) != 0) ? 12'hFFF : 12'h000;
                default: begin
                    c = 4'((x >> 4) & 15);
                    p.rgb = {c, c, c};
                end
            endcase
`ifdef VGA_BORDER_EN
            if (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) p.rgb = 12'hFFF;
`endif
        end
        return p;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (model x=%0d y=%0d)", tag, obs, expv, m_h, m_v);
        end
    endtask

    task automatic check_pix(input string tag, input pix_t e);
        pix_t o;
        o = {oHS, oVS, oDE, oRed, oGreen, oBlue, oX, oY};
        check(tag, 64'(o), 64'(e));
    endtask

    task automatic model_start();
        m_h = 0; m_v = 0; k = 0;
        m_mode = 2'd0; m_solid = 12'h000; m_frame = 16'd0;
        de_cnt = 0; hs_cnt = 0;
        hist.delete();
        hist.push_back(model(0, 0, m_mode, m_solid));
        check_pix("start_pix", reset_pix());
        check("start_frame", 64'(oFrame), 64'(m_frame));
    endtask

    task automatic tick();
        pix_t e;
        @(posedge clk);
        if (m_h == HT - 1 && m_v == VT - 1) begin
            m_mode  = mode;
            m_solid = solid;
            m_frame = m_frame + 16'd1;
        end
        if (m_h == HT - 1) begin
            m_h = 0;
            m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end else begin
            m_h++;
        end
        k++;
        @(negedge clk);
        hist.push_back(model(m_h, m_v, m_mode, m_solid));
        if (hist.size() > 3) void'(hist.pop_front());
        if (k < 2) begin
            check_pix("pipe_fill", reset_pix());
        end else begin
            e = hist[0];
            check_pix("pixel", e);
            if (oDE) de_cnt++;
            if (oHS == HSP) hs_cnt++;
            if (e.x == 11'(HT - 1) && e.y == 11'(VT - 1)) begin
                check("de_per_frame", 64'(de_cnt), 64'(HA * VA));
                check("hs_per_frame", 64'(hs_cnt), 64'(HSY * VT));
                de_cnt = 0;
                hs_cnt = 0;
            end
        end
        check("frame_cnt", 64'(oFrame), 64'(m_frame));
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_pix("rst_async", reset_pix());
        check("rst_frame", 64'(oFrame), 64'(0));
        repeat (n) begin
            @(negedge clk);
            check_pix("rst_hold", reset_pix());
            check("rst_hold_frame", 64'(oFrame), 64'(0));
        end
        rst_n = 1'b1;
        #1;
        model_start();
    endtask

    initial begin
        // Power-on reset, then frame 0 must be black even though bars are requested
        mode  = 2'd1;
        solid = 12'($urandom);
        do_reset(3);
        $display("step reset: frame=%0d", oFrame);
        run(HT * VT + HT * 3);
        $display("step first frames: mode=%0d frame=%0d", m_mode, oFrame);

        // Solid colour requested mid-frame, then switch to checker at line 200-equivalent mid-frame
        mode  = 2'd0;
        solid = 12'($urandom);
        run(HT * VT);
        $display("step solid: solid=%03h frame=%0d", m_solid, oFrame);
        run(HT * (VA / 2));
        mode = 2'd2;
        $display("step switch to checker at line %0d", m_v);
        run(HT * VT * 2);
        $display("step checker: mode=%0d frame=%0d", m_mode, oFrame);

        mode = 2'd3;
        run(HT * VT + 17);
        $display("step gradient: mode=%0d frame=%0d", m_mode, oFrame);

        for (int i = 0; i < 6; i++) begin
            mode  = 2'($urandom_range(0, 3));
            solid = 12'($urandom);
            run(int'($urandom_range(HT * VT / 2, HT * VT * 2)));
            $display("step random %0d: mode=%0d solid=%03h frame=%0d", i, m_mode, m_solid, oFrame);
        end

        // Reset mid-frame, restart from (0,0) with a fresh frame count
        mode = 2'd1;
        run(HT * 5 + 37);
        do_reset(3);
        $display("step mid-frame reset: frame=%0d", oFrame);
        run(HT * VT * 2 + 10);
        $display("step after reset: mode=%0d frame=%0d", m_mode, oFrame);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
